bpred_unit: RTL and testbench
=============================

# bpred_unit

Parametrised branch prediction unit for the 5-stage RV32I core. It merges the separate BTB and bimodal predictor into one block with:
- configurable table depth, tag width, counter width and global history length;
- optional gshare indexing;
- resolution-time mispredict detection;
- performance counters.

Lookup happens in F against the fetch PC. Update happens in D when a conditional branch resolves.

## Interface
Parameters:
- INDEX_SIZE, default 6: log2 of entry count for both the BTB and the counter table.
- TAG_SIZE, default 8: BTB tag width, taken from pc[INDEX_SIZE+2 +: TAG_SIZE].
- CNT_WIDTH, default 2: saturating counter width, range 1..4.
- GHR_WIDTH, default 6: global history length, at most INDEX_SIZE.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- pcF  in  32  fetch PC
- btb_hitF  out  1  valid BTB entry with matching tag at pcF
- predF  out  1  taken prediction (MSB of the indexed counter)
- targetF  out  32  BTB target for pcF
- ghrF  out  GHR_WIDTH  history snapshot used for the pcF lookup; carried down the pipe
- upd_validD  in  1  a conditional branch resolves in D this cycle
- stallD  in  1  D stage held; blocks updates
- pcD  in  32  PC of the resolving branch
- ghrD  in  GHR_WIDTH  snapshot carried from F with that branch
- btb_hitD, predD  in  1 each  F-stage prediction carried with the branch
- takenD  in  1  actual outcome
- targetD  in  32  computed target (pcD + branchimm)
- mispredictD  out  1  combinational: upd_validD & ((btb_hitD & predD) != takenD)
- br_countW  out  32  resolved branch count
- mispred_countW  out  32  mispredict count

## Operation
- BTB entry fields: valid, tag, target. BTB index is pc[INDEX_SIZE+1:2].
- Counter table: 2^INDEX_SIZE entries of CNT_WIDTH bits.
- Counter index in F is f(pcF, GHR). Counter index in D is f(pcD, ghrD). f depends on the configuration macro.
- Lookup is fully combinational: btb_hitF, predF, targetF and ghrF all derive from pcF and the current state.
- Update fires when upd_validD & !stallD, at the clock edge:
  - Counter: increments if takenD, decrements otherwise. It saturates at 2^CNT_WIDTH-1 and at 0; no wrap.
  - BTB entry at the pcD index is written valid=1 with the pcD tag and targetD, on every update. A write replaces any existing entry, including an aliased one.
  - GHR becomes {GHR[GHR_WIDTH-2:0], takenD}. History is non-speculative, changed only at resolution.
  - br_countW increments. mispred_countW increments if mispredictD. Both wrap modulo 2^32.
- While stallD is high, no state changes. mispredictD still reflects its inputs.

## Timing
- Lookup latency is 0 cycles. State written at edge N is visible to lookups from edge N onward.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
- Reset asserted, including mid-update:
  - all valid bits clear;
  - counters go to 2^(CNT_WIDTH-1)-1 (weakly not-taken; 0 when CNT_WIDTH=1);
  - GHR clears to 0;
  - perf counters clear to 0.
- Outputs during reset: btb_hitF=0, predF=0, targetF is don't-care, ghrF=0.
- An update coincident with reset deassertion is taken on the next active edge only when reset is low at that edge.

## Configuration
- BPRED_GSHARE_EN defined: counter index = pc[INDEX_SIZE+1:2] XOR zero-extended history. History is GHR in F and ghrD in D.
- BPRED_GSHARE_EN undefined: counter index = pc[INDEX_SIZE+1:2] (bimodal).
  - The GHR register and ghrF output still exist and still update, so the pipeline interface is identical.
  - The ghrD input is ignored.
- BTB indexing is unaffected by the macro.

## Test plan
- Reset defaults (CNT_WIDTH=2): assert reset, then lookup pcF=0x100 → btb_hitF=0, predF=0, ghrF=0; both perf counters read 0.
- Saturation, bimodal: 4 updates at pcD=0x100 with takenD=1 and targetD=0x180 → lookup pcF=0x100 gives btb_hitF=1, predF=1, targetF=0x180. Then 1 not-taken update → predF stays 1 (counter 3→2). Then 2 more not-taken updates → predF=0, counter floor is 0.
- Tag alias: update pcD=0x100, target 0x200; then update pcD=0x100+(4<<INDEX_SIZE), target 0x300 → lookup 0x100 gives btb_hitF=0; lookup of the aliased PC gives targetF=0x300.
- Mispredict and counters: 10 updates with btb_hitD=1, predD=1, takenD alternating 1,0 → mispredictD high on the 5 not-taken cycles; br_countW=10, mispred_countW=5.
- Stall and same-cycle access: updates with stallD=1 → no state or counter change. Update and lookup on the same index in one cycle → lookup shows the old counter value; the next cycle shows the new one.
- Gshare (BPRED_GSHARE_EN, GHR_WIDTH=6): 6 taken updates from any PCs → ghrF=6'b111111. A lookup at pcF=0x100 indexes entry (0x40 ^ 0x3F) & mask; verify by priming that entry with 2 taken updates whose pcD and ghrD map to the same index.

Source files
------------

// File: rtl/bpred_unit_if.sv
// bpred_unit_if: fetch-lookup, decode-update and perf-counter signals of the branch predictor
interface bpred_unit_if #(
    parameter int GHR_WIDTH = 6
);
    logic [31:0]          pcF;
    logic                 btb_hitF;
    logic                 predF;
    logic [31:0]          targetF;
    logic [GHR_WIDTH-1:0] ghrF;
    logic                 upd_validD;
    logic                 stallD;
    logic [31:0]          pcD;
    logic [GHR_WIDTH-1:0] ghrD;
    logic                 btb_hitD;
    logic                 predD;
    logic                 takenD;
    logic [31:0]          targetD;
    logic                 mispredictD;
    logic [31:0]          br_countW;
    logic [31:0]          mispred_countW;

    modport master (
        output pcF, upd_validD, stallD, pcD, ghrD, btb_hitD, predD, takenD, targetD,
        input  btb_hitF, predF, targetF, ghrF, mispredictD, br_countW, mispred_countW
    );

    modport slave (
        input  pcF, upd_validD, stallD, pcD, ghrD, btb_hitD, predD, takenD, targetD,
        output btb_hitF, predF, targetF, ghrF, mispredictD, br_countW, mispred_countW
    );
endinterface

// File: rtl/bpred_unit.sv
// bpred_unit: BTB + saturating-counter predictor with global history; gshare indexing when BPRED_GSHARE_EN is defined
module bpred_unit #(
    parameter int INDEX_SIZE = 6,
    parameter int TAG_SIZE   = 8,
    parameter int CNT_WIDTH  = 2,
    parameter int GHR_WIDTH  = 6
) (
    input  logic      clk,
    input  logic      reset,
    bpred_unit_if.slave bp
);
    localparam int N = 1 << INDEX_SIZE;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    logic [N-1:0]          valid_q;
    logic [TAG_SIZE-1:0]   tag_q [N];
    logic [31:0]           tgt_q [N];
    logic [CNT_WIDTH-1:0]  cnt_q [N];
    logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
    logic [31:0]           br_count_q, br_count_d;
    logic [31:0]           mispred_count_q, mispred_count_d;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [INDEX_SIZE-1:0] lk_idx, lk_cidx, up_idx, up_cidx;
    logic [TAG_SIZE-1:0]   lk_tag, up_tag;
    logic [CNT_WIDTH-1:0]  up_cnt;
    logic                  upd;
    logic                  unused_bits;

    assign unused_bits = ^{bp.pcF[1:0], bp.pcF[31:INDEX_SIZE+TAG_SIZE+2],
                           bp.pcD[1:0], bp.pcD[31:INDEX_SIZE+TAG_SIZE+2], bp.ghrD};

    // index/tag extraction, counter next value and all combinational outputs
    always_comb begin
        lk_idx = bp.pcF[INDEX_SIZE+1:2];
        up_idx = bp.pcD[INDEX_SIZE+1:2];
        lk_tag = bp.pcF[INDEX_SIZE+2 +: TAG_SIZE];
        up_tag = bp.pcD[INDEX_SIZE+2 +: TAG_SIZE];
`ifdef BPRED_GSHARE_EN
        lk_cidx = lk_idx ^ INDEX_SIZE'(ghr_q);
        up_cidx = up_idx ^ INDEX_SIZE'(bp.ghrD);
`else
        lk_cidx = lk_idx;
        up_cidx = up_idx;
`endif
        upd    = bp.upd_validD & ~bp.stallD;
        up_cnt = cnt_q[up_cidx];
        cnt_d  = bp.takenD ? ((up_cnt == CNT_MAX) ? up_cnt : up_cnt + CNT_WIDTH'(1))
                           : ((up_cnt == '0) ? up_cnt : up_cnt - CNT_WIDTH'(1));
        ghr_d  = GHR_WIDTH'({ghr_q, bp.takenD});
        bp.mispredictD  = bp.upd_validD & ((bp.btb_hitD & bp.predD) != bp.takenD);
        br_count_d      = br_count_q + 32'd1;
        mispred_count_d = mispred_count_q + 32'(bp.mispredictD);
        bp.btb_hitF       = ~reset & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        bp.predF          = ~reset & cnt_q[lk_cidx][CNT_WIDTH-1];
        bp.targetF        = tgt_q[lk_idx];
        bp.ghrF           = ghr_q;
        bp.br_countW      = br_count_q;
        bp.mispred_countW = mispred_count_q;
    end

    // resettable predictor state: valid bits, counters, history, perf counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= CNT_INIT;
            ghr_q           <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (upd) begin
            valid_q[up_idx]  <= 1'b1;
            cnt_q[up_cidx]   <= cnt_d;
            ghr_q            <= ghr_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    // BTB payload needs no reset since the valid bits qualify it
    always_ff @(posedge clk) begin
        if (upd && !reset) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= bp.targetD;
        end
    end
endmodule

// File: tb/tb_bpred_unit.sv
// tb_bpred_unit: vector table, hand sequences and randomized run against a reference model of bpred_unit
module tb_bpred_unit;
    localparam int IS = 6, TS = 8, CW = 2, GW = 6;
    localparam int N = 1 << IS, CMAX = (1 << CW) - 1, CINIT = (1 << (CW - 1)) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpred_unit_if #(.GHR_WIDTH(GW)) bp ();
    bpred_unit #(.INDEX_SIZE(IS), .TAG_SIZE(TS), .CNT_WIDTH(CW), .GHR_WIDTH(GW))
        dut (.clk(clk), .reset(reset), .bp(bp.slave));

    int n_cmp = 0, n_bad = 0;
    bit          m_valid [N];
    int          m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    int          m_ghr;
    int unsigned m_br, m_mp;

    typedef struct {
        logic [31:0] pcf; bit upd; bit stall; logic [31:0] pcd; bit taken; logic [31:0] tgt; bit hitd; bit predd;
        bit e_hit; bit e_pred; logic [31:0] e_tgt; bit e_mis;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cidx(input logic [31:0] pc, input int h);
`ifdef BPRED_GSHARE_EN
        return int'(((pc >> 2) ^ 32'(h)) % N);
`else
        return int'((pc >> 2) % N) + 0 * h;
`endif
    endfunction

    function automatic bit exp_mis();
        return bp.upd_validD && ((bp.btb_hitD && bp.predD) != bp.takenD);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = CINIT;
        end
        m_ghr = 0;
        m_br  = 0;
        m_mp  = 0;
    endtask

    task automatic m_update();
        if (bp.upd_validD && !bp.stallD) begin
            int i = int'((bp.pcD >> 2) % N);
            int c = cidx(bp.pcD, int'(bp.ghrD));
            if (exp_mis()) m_mp++;
            m_br++;
            m_valid[i] = 1;
            m_tag[i]   = int'((bp.pcD >> (IS + 2)) % (1 << TS));
            m_tgt[i]   = bp.targetD;
            m_cnt[c]   = bp.takenD ? ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX)
                                   : ((m_cnt[c] > 0) ? m_cnt[c] - 1 : 0);
            m_ghr      = ((m_ghr << 1) | int'(bp.takenD)) % (1 << GW);
        end
    endtask

    task automatic check_lookup();
        int i   = int'((bp.pcF >> 2) % N);
        bit hit = m_valid[i] && (m_tag[i] == int'((bp.pcF >> (IS + 2)) % (1 << TS)));
        chk("btb_hitF", bp.btb_hitF, hit);
        chk("predF", bp.predF, m_cnt[cidx(bp.pcF, m_ghr)] > CINIT);
        if (hit) chk("targetF", bp.targetF, m_tgt[i]);
        chk("ghrF", bp.ghrF, m_ghr);
        chk("mispredictD", bp.mispredictD, exp_mis());
    endtask

    task automatic drive(input logic [31:0] pcf, input bit upd, input bit stall, input logic [31:0] pcd,
                         input bit taken, input logic [31:0] tgt, input bit hitd, input bit predd,
                         input logic [GW-1:0] ghrd);
        bp.pcF        = pcf;
        bp.upd_validD = upd;
        bp.stallD     = stall;
        bp.pcD        = pcd;
        bp.takenD     = taken;
        bp.targetD    = tgt;
        bp.btb_hitD   = hitd;
        bp.predD      = predd;
        bp.ghrD       = ghrd;
    endtask

    task automatic idle(input logic [31:0] pcf);
        drive(pcf, 0, 0, 32'h0, 0, 32'h0, 0, 0, '0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_lookup();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(32'h100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    function automatic logic [31:0] rpc();
        return 32'(($urandom_range(0, 3) << (IS + 2)) | ($urandom_range(0, 7) << 2));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h100, 1, 0, 32'h100, 1, 32'h180, 0, 0, 0, 0, 32'h0,   1};
        tbl[1]  = '{32'h100, 1, 0, 32'h100, 1, 32'h180, 0, 0, 1, 1, 32'h180, 1};
        tbl[2]  = '{32'h100, 1, 0, 32'h100, 1, 32'h180, 1, 1, 1, 1, 32'h180, 0};
        tbl[3]  = '{32'h100, 1, 0, 32'h100, 1, 32'h180, 1, 1, 1, 1, 32'h180, 0};
        tbl[4]  = '{32'h100, 1, 0, 32'h100, 0, 32'h180, 1, 1, 1, 1, 32'h180, 1};
        tbl[5]  = '{32'h100, 1, 0, 32'h100, 0, 32'h180, 1, 1, 1, 1, 32'h180, 1};
        tbl[6]  = '{32'h100, 1, 0, 32'h100, 0, 32'h180, 1, 1, 1, 0, 32'h180, 1};
        tbl[7]  = '{32'h100, 1, 0, 32'h100, 0, 32'h180, 1, 1, 1, 0, 32'h180, 1};
        tbl[8]  = '{32'h100, 0, 0, 32'h100, 0, 32'h180, 0, 0, 1, 0, 32'h180, 0};
        tbl[9]  = '{32'h100, 1, 0, 32'h100, 1, 32'h180, 0, 0, 1, 0, 32'h180, 1};
        tbl[10] = '{32'h100, 0, 0, 32'h100, 0, 32'h180, 0, 0, 1, 0, 32'h180, 0};
        tbl[11] = '{32'h100, 1, 1, 32'h100, 1, 32'h999, 0, 0, 1, 0, 32'h180, 1};
        tbl[12] = '{32'h100, 0, 0, 32'h100, 0, 32'h0,   0, 0, 1, 0, 32'h180, 0};
        tbl[13] = '{32'h100, 1, 0, 32'h200, 0, 32'h300, 0, 0, 1, 0, 32'h180, 0};
        tbl[14] = '{32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,   0};
        tbl[15] = '{32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h300, 0};

        reset = 1'b1;
        idle(32'h100);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", bp.btb_hitF, 0);
        chk("rst_pred", bp.predF, 0);
        chk("rst_ghr", bp.ghrF, 0);
        chk("rst_br", bp.br_countW, 0);
        chk("rst_mp", bp.mispred_countW, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_hit", bp.btb_hitF, 0);
        chk("post_rst_pred", bp.predF, 0);
        @(posedge clk);
        #1;

`ifndef BPRED_GSHARE_EN
        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].pcf, tbl[k].upd, tbl[k].stall, tbl[k].pcd, tbl[k].taken, tbl[k].tgt,
                  tbl[k].hitd, tbl[k].predd, '0);
            @(negedge clk);
            chk($sformatf("vec%0d_hit", k), bp.btb_hitF, tbl[k].e_hit);
            chk($sformatf("vec%0d_pred", k), bp.predF, tbl[k].e_pred);
            if (tbl[k].e_hit) chk($sformatf("vec%0d_tgt", k), bp.targetF, tbl[k].e_tgt);
            chk($sformatf("vec%0d_mis", k), bp.mispredictD, tbl[k].e_mis);
            @(posedge clk);
            m_update();
            #1;
        end
        idle(32'h100);
        @(negedge clk);
        chk("vec_br_count", bp.br_countW, 10);
        chk("vec_mp_count", bp.mispred_countW, 7);
        chk("vec_ghr", bp.ghrF, 6'b000010);
        @(posedge clk);
        #1;
`endif

        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(32'h40, 1, 0, 32'h40, (k % 2) == 0, 32'h800, 1, 1, '0);
            @(negedge clk);
            chk($sformatf("alt%0d_mis", k), bp.mispredictD, (k % 2) != 0);
            @(posedge clk);
            m_update();
            #1;
        end
        idle(32'h40);
        @(negedge clk);
        chk("alt_br_count", bp.br_countW, 10);
        chk("alt_mp_count", bp.mispred_countW, 5);
        @(posedge clk);
        #1;

`ifdef BPRED_GSHARE_EN
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(32'h100, 1, 0, 32'h104, 1, 32'h500, 0, 0, '0);
            cycle();
        end
        idle(32'h100);
        @(negedge clk);
        chk("gs_ghr", bp.ghrF, 6'h3F);
        chk("gs_pred_before", bp.predF, 0);
        for (int k = 0; k < 2; k++) begin
            drive(32'h100, 1, 0, 32'h100, 1, 32'h500, 0, 0, 6'h3F);
            cycle();
        end
        idle(32'h100);
        @(negedge clk);
        chk("gs_pred_after", bp.predF, 1);
        @(posedge clk);
        #1;
`endif

        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(rpc(), $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, rpc(), 1'($urandom),
                  $urandom, 1'($urandom), 1'($urandom), GW'($urandom));
            cycle();
            if (k % 50 == 49) begin
                chk("rnd_br_count", bp.br_countW, m_br);
                chk("rnd_mp_count", bp.mispred_countW, m_mp);
            end
        end

        drive(32'h140, 1, 0, 32'h140, 1, 32'h7A0, 0, 0, '0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_hit", bp.btb_hitF, 0);
        chk("midrst_pred", bp.predF, 0);
        chk("midrst_ghr", bp.ghrF, 0);
        chk("midrst_br", bp.br_countW, 0);
        chk("midrst_mp", bp.mispred_countW, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        cycle();
        idle(32'h140);
        @(negedge clk);
        chk("midrst_after_hit", bp.btb_hitF, 1);
        chk("midrst_after_tgt", bp.targetF, 32'h7A0);
        chk("midrst_after_br", bp.br_countW, 1);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
